// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit holding the architectural HI/LO registers.
// Multiply is LSB-first shift-add; divide is MSB-first restoring division on magnitudes.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   orig_a_q, orig_a_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               sgn_op;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, prod;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   diff;
  logic               take;
  logic [WIDTH-1:0]   rem_next, quo_next;

  // Iteration datapaths; acc holds {partial product, multiplier} or {unused, dividend/quotient}.
  always_comb begin
    sgn_op   = ~op_i[0];
    mag_a    = (sgn_op && src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
    mag_b    = (sgn_op && src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    prod     = neg_q_q ? -mul_next : mul_next;
    rem_sh   = {rem_q, acc_q[WIDTH-1]};
    diff     = {1'b0, rem_sh} - {2'b00, opnd_q};
    take     = ~diff[WIDTH+1];
    rem_next = take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_next = {acc_q[WIDTH-2:0], take};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    orig_a_d = orig_a_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    busy_d   = busy_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = RUN;
          cnt_d    = '0;
          busy_d   = 1'b1;
          is_div_d = op_i[1];
          neg_q_d  = sgn_op & (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
          neg_r_d  = sgn_op & src_a_i[WIDTH-1];
          div0_d   = (src_b_i == '0);
          orig_a_d = src_a_i;
          opnd_d   = op_i[1] ? mag_b : mag_a;
          acc_d    = {{WIDTH{1'b0}}, (op_i[1] ? mag_a : mag_b)};
          rem_d    = '0;
        end else begin
          if (mthi_i) hi_d = wdata_i;
          if (mtlo_i) lo_d = wdata_i;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (is_div_q) begin
          acc_d = {acc_q[2*WIDTH-1:WIDTH], quo_next};
          rem_d = rem_next;
        end else begin
          acc_d = mul_next;
        end
        if (cnt_q == 5'd31) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (!is_div_q) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (div0_q) begin
            hi_d = orig_a_q;
            lo_d = '1;
          end else begin
            hi_d = neg_r_q ? -rem_next : rem_next;
            lo_d = neg_q_q ? -quo_next : quo_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      orig_a_q <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
      orig_a_q <= orig_a_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy_o = busy_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus random ops against an arithmetic model.
module tb_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        reset_i, start_i, mthi_i, mtlo_i;
  logic [1:0]  op_i;
  logic [31:0] src_a_i, src_b_i, wdata_i;
  logic        busy_o;
  logic [31:0] hi_o, lo_o;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .op_i(op_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .mthi_i(mthi_i), .mtlo_i(mtlo_i),
    .wdata_i(wdata_i), .busy_o(busy_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic with the architectural special cases.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ehi, output logic [31:0] elo);
    logic [63:0] p;
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = 64'(sa * sb); ehi = p[63:32]; elo = p[31:0]; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; ehi = p[63:32]; elo = p[31:0]; end
      2'b10: begin
        if (b == 0) begin ehi = a; elo = '1; end
        else begin
          q = sa / sb; r = sa % sb;
          p = 64'(q); elo = p[31:0];
          p = 64'(r); ehi = p[31:0];
        end
      end
      default: begin
        if (b == 0) begin ehi = a; elo = '1; end
        else begin elo = a / b; ehi = a % b; end
      end
    endcase
  endtask

  // mode: 0 plain, 1 second start at run cycle 5, 2 mthi at run cycle 7, 3 mthi with start
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int mode);
    logic [31:0] ehi, elo, hi0, lo0;
    int n;
    int hold_err;
    model(op, a, b, ehi, elo);
    @(negedge clk_i);
    hi0 = hi_o; lo0 = lo_o;
    start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
    if (mode == 3) begin mthi_i = 1'b1; wdata_i = 32'h5555_5555; end
    @(posedge clk_i); #1;
    start_i = 1'b0; mthi_i = 1'b0;
    src_a_i = $urandom; src_b_i = $urandom; op_i = 2'($urandom);
    n = 0; hold_err = 0;
    while (busy_o && n < 40) begin
      if (hi_o !== hi0 || lo_o !== lo0) hold_err++;
      if (mode == 1 && n == 5) begin
        start_i = 1'b1; op_i = 2'b00; src_a_i = 32'd3; src_b_i = 32'd5;
      end
      if (mode == 2 && n == 7) begin mthi_i = 1'b1; wdata_i = 32'hDEAD_BEEF; end
      @(posedge clk_i); #1;
      start_i = 1'b0; mthi_i = 1'b0;
      n++;
    end
    chk({tag, "_busy_len"}, 64'(n), 64'd32);
    chk({tag, "_hold"}, 64'(hold_err), 64'd0);
    chk({tag, "_hi"}, {32'd0, hi_o}, {32'd0, ehi});
    chk({tag, "_lo"}, {32'd0, lo_o}, {32'd0, elo});
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset_i = 1'b1; start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0;
    op_i = 2'b00; src_a_i = '0; src_b_i = '0; wdata_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_hi", {32'd0, hi_o}, 64'd0);
    chk("rst_lo", {32'd0, lo_o}, 64'd0);
    @(negedge clk_i); reset_i = 1'b0;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("multu_max_const", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 0);
    chk("mult_m3x7_const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    chk("mult_minsq_const", {hi_o, lo_o}, 64'h4000_0000_0000_0000);
    run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_m7d2_const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_7d2", 2'b11, 32'd7, 32'd2, 0);
    chk("divu_7d2_const", {hi_o, lo_o}, 64'h0000_0001_0000_0003);
    run_op("divu_by0", 2'b11, 32'd5, 32'd0, 0);
    chk("divu_by0_const", {hi_o, lo_o}, 64'h0000_0005_FFFF_FFFF);
    run_op("div_by0", 2'b10, 32'hFFFF_FFF0, 32'd0, 0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_ovf_const", {hi_o, lo_o}, 64'h0000_0000_8000_0000);
    run_op("div_neg_rem", 2'b10, 32'd7, 32'hFFFF_FFFE, 0);
    run_op("divu_restart", 2'b11, 32'd100, 32'd7, 1);
    run_op("mult_mthi_busy", 2'b00, 32'd1234, 32'hFFFF_FF00, 2);
    run_op("divu_start_wins", 2'b11, 32'd7, 32'd2, 3);

    // Reset at run cycle 10 aborts and zeroes HI/LO
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b00; src_a_i = 32'd99; src_b_i = 32'd77;
    @(posedge clk_i); #1; start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1; reset_i = 1'b1;
    @(posedge clk_i); #1; reset_i = 1'b0;
    chk("abort_busy", {63'd0, busy_o}, 64'd0);
    chk("abort_hi", {32'd0, hi_o}, 64'd0);
    chk("abort_lo", {32'd0, lo_o}, 64'd0);

    mtlo_i = 1'b1; wdata_i = 32'h1234;
    @(posedge clk_i); #1; mtlo_i = 1'b0;
    chk("mtlo_lo", {32'd0, lo_o}, 64'h1234);
    chk("mtlo_hi", {32'd0, hi_o}, 64'd0);
    mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = 32'hABCD_0123;
    @(posedge clk_i); #1; mthi_i = 1'b0; mtlo_i = 1'b0;
    chk("mtboth", {hi_o, lo_o}, 64'hABCD_0123_ABCD_0123);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: ra = $urandom;
        1: ra = $urandom_range(0, 20);
        2: ra = 32'hFFFF_FFFF - $urandom_range(0, 20);
        default: ra = 32'h8000_0000;
      endcase
      case ($urandom_range(0, 4))
        0, 1: rb = $urandom;
        2: rb = $urandom_range(0, 9);
        3: rb = 32'hFFFF_FFFF - $urandom_range(0, 9);
        default: rb = $urandom_range(0, 1) ? 32'h8000_0000 : 32'd0;
      endcase
      run_op($sformatf("rnd%0d", i), 2'($urandom), ra, rb, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, alongside the ALU.
- Consumes the EX operand-select outputs src_a/src_b. Holds the architectural HI/LO registers for mult, multu, div, divu, mthi, mtlo, mfhi and mflo.
- Each operation takes a fixed 32 busy cycles.
- The hazard unit stalls on (start | busy) for any following muldiv/mfhi/mflo/mthi/mtlo instruction.

Parameters:
- WIDTH, 32, operand width; only 32 is supported.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  launch operation; sampled on the rising edge.
- op  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start.
- src_a  input  32  multiplicand / dividend; sampled with start.
- src_b  input  32  multiplier / divisor; sampled with start.
- mthi  input  1  write wdata into HI.
- mtlo  input  1  write wdata into LO.
- wdata  input  32  source for mthi/mtlo.
- busy  output  1  operation in progress (registered).
- hi  output  32  HI register (registered).
- lo  output  32  LO register (registered).

Behaviour:
- Reset:
  - busy=0, hi=0, lo=0, state=IDLE, counter=0.
  - Reset mid-operation aborts the operation: the result is discarded and HI/LO are zeroed.
- States: IDLE, RUN. 5-bit iteration counter.
- IDLE with start=1 at edge T:
  - Latch op and operands.
  - For signed ops, latch the magnitudes |src_a| and |src_b| plus the result signs:
    - product sign = sign_a XOR sign_b;
    - quotient sign = sign_a XOR sign_b;
    - remainder sign = sign_a.
  - Go to RUN with counter=0 and busy=1 from T+1.
- RUN: one iteration per cycle; the counter increments and exits after 32 iterations.
  - Multiply: shift-add on an unsigned 64-bit accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring division, one quotient bit per cycle, MSB first, 33-bit partial remainder.
- Completion (edge ending the 32nd RUN cycle, i.e. edge T+32):
  - Apply sign correction (two's complement negate where required).
  - Multiply: {hi,lo} = 64-bit product.
  - Divide: lo = quotient, truncated toward zero; hi = remainder, same sign as the dividend.
  - busy=0 and state=IDLE from T+33; new hi/lo are visible at T+33.
- Latency: start at edge T -> result visible after edge T+32; busy is high for exactly 32 cycles.
- Divide by zero (div and divu): lo=32'hFFFFFFFF, hi=dividend as originally supplied (signed value for div). Still takes 32 cycles.
- Signed overflow, div 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0.
- start while busy=1: ignored; the running operation continues unaffected.
- mthi/mtlo:
  - Take effect on the edge they are sampled, only when state=IDLE and start=0.
  - Ignored while busy, or when start is asserted in the same cycle (start wins).
  - mthi and mtlo together write wdata to both registers.
- hi/lo hold their value during RUN; intermediate values never appear on them.
- Width rules:
  - Operands are WIDTH bits; the product is 2*WIDTH bits.
  - Magnitude of 32'h80000000 is handled as unsigned 2^31 (no overflow in the magnitude path).

Test Plan:
- multu 32'hFFFFFFFF x 32'hFFFFFFFF -> busy high for 32 cycles, then hi=32'hFFFFFFFE, lo=32'h00000001.
- mult -3 x 7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB. mult 32'h80000000 x 32'h80000000 -> hi=32'h40000000, lo=0.
- div -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. divu 7 / 2 -> lo=3, hi=1.
- Corner cases:
  - divu 5 / 0 -> lo=32'hFFFFFFFF, hi=5.
  - div 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- Reset and protocol checks:
  - Assert reset at RUN cycle 10 of a mult -> next cycle busy=0, hi=lo=0.
  - Then mtlo 32'h1234 with start=0 -> lo=32'h1234 after one edge.
  - A second start at cycle 5 of a running divu is ignored; the result matches the first operands at cycle 32.
  - mthi asserted during busy is ignored; hi is unchanged.
